rpn_exec: RTL and testbench

RPN_EXEC -- requirements
Module: rpn_exec

---
 rtl/rpn_pkg.sv | 29 ++
 rtl/rpn_stack.sv | 55 +++++
 rtl/rpn_exec.sv | 143 ++++++++++++++
 tb/tb_rpn_exec.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN executor: operator codes, error codes, FSM states.
// No logic lives here.
// A helper sizes the entry-count field.
package rpn_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_POP  = 4'd4;
    localparam logic [3:0] OP_NONE = 4'hF;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_OVF  = 3'd1,
        ERR_UNF  = 3'd2,
        ERR_UNK  = 3'd3,
        ERR_DIV0 = 3'd4
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    function automatic int depth_w(input int d);
        return $clog2(d) + 1;
    endfunction
endpackage

// File: rtl/rpn_stack.sv
// LIFO operand stack with push, pop and pop-then-replace-top; exposes top and second entries.
// Latency: updates land on the clock edge; top/second/depth are combinational from state.
// Backpressure: none; the caller guarantees push only when not full and pops only when deep enough.
module rpn_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_repl,
    input  logic [WIDTH-1:0]         i_dat,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic [WIDTH-1:0]         o_top,
    output logic [WIDTH-1:0]         o_second
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = depth_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_cnt;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_sec_idx;
    logic [AW-1:0]    w_push_idx;

    assign w_top_idx  = AW'(r_cnt - DW'(1));
    assign w_sec_idx  = AW'(r_cnt - DW'(2));
    assign w_push_idx = AW'(r_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_push) begin
            r_cnt <= r_cnt + DW'(1);
        end else if (i_pop || i_repl) begin
            r_cnt <= r_cnt - DW'(1);
        end
    end

    // Storage is never cleared: entries above r_cnt are not observable.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_push_idx] <= i_dat;
        end else if (i_repl) begin
            r_mem[w_sec_idx] <= i_dat;
        end
    end

    assign o_depth  = r_cnt;
    assign o_top    = (r_cnt != '0)     ? r_mem[w_top_idx] : '0;
    assign o_second = (r_cnt > DW'(1))  ? r_mem[w_sec_idx] : '0;
endmodule

// File: rtl/rpn_exec.sv
// RPN token executor: numbers push, operators run through an external combinational ALU.
// Latency: number 1 cycle; operator accept N, EXEC N+1, WB N+2, ready again N+3.
// Backpressure: tok_ready only in IDLE, one token in flight. RPN_DIV0_CHECK_EN traps divide by zero.
module rpn_exec
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tok_valid,
    output logic                     tok_ready,
    input  logic                     tok_is_op,
    input  logic [3:0]               tok_op,
    input  logic [WIDTH-1:0]         tok_num,
    output logic [3:0]               alu_op,
    output logic [WIDTH-1:0]         alu_left,
    output logic [WIDTH-1:0]         alu_right,
    input  logic [WIDTH-1:0]         alu_ans,
    input  logic [1:0]               alu_arg_cnt,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     res_valid,
    output logic                     err,
    output logic [2:0]               err_code
);
    localparam int DW = depth_w(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_ans;
    logic [1:0]       r_argc;
    logic             r_err;
    err_t             r_err_code;

    logic             w_acc;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_repl;
    err_t             w_exec_err;
    logic             w_exec_ok;
    logic [DW-1:0]    w_depth;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_second;

    rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_repl   (w_repl),
        .i_dat    (w_push ? tok_num : r_ans),
        .o_depth  (w_depth),
        .o_top    (w_top),
        .o_second (w_second)
    );

    assign w_acc  = tok_valid && tok_ready;
    assign w_full = (w_depth == DW'(DEPTH));
    assign w_push = w_acc && !tok_is_op && !w_full;
    assign w_pop  = rst_n && (r_state == S_WB) && (r_argc == 2'd1);
    assign w_repl = rst_n && (r_state == S_WB) && (r_argc == 2'd2);

    // Operand check on the ALU's verdict for the latched operator.
    always_comb begin
        w_exec_err = ERR_NONE;
        if (alu_arg_cnt == 2'd0 || alu_arg_cnt == 2'd3) begin
            w_exec_err = ERR_UNK;
        end else if (w_depth < DW'(alu_arg_cnt)) begin
            w_exec_err = ERR_UNF;
        end
`ifdef RPN_DIV0_CHECK_EN
        else if (r_op == OP_DIV && alu_arg_cnt == 2'd2 && w_top == '0) begin
            w_exec_err = ERR_DIV0;
        end
`endif
    end
    assign w_exec_ok = (w_exec_err == ERR_NONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && tok_is_op) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_exec_ok ? S_WB : S_IDLE;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tok_ready = 1'b0;
        res_valid = 1'b0;
        alu_op    = OP_NONE;
        case (r_state)
            S_IDLE:  tok_ready = rst_n;
            S_EXEC:  alu_op    = r_op;
            S_WB:    res_valid = rst_n;
            default: tok_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op       <= OP_NONE;
            r_ans      <= '0;
            r_argc     <= 2'd0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_acc) begin
            // Any accepted token clears the previous error unless it fails itself.
            r_err      <= !tok_is_op && w_full;
            r_err_code <= (!tok_is_op && w_full) ? ERR_OVF : ERR_NONE;
            if (tok_is_op) begin
                r_op <= tok_op;
            end
        end else if (r_state == S_EXEC) begin
            r_ans  <= alu_ans;
            r_argc <= alu_arg_cnt;
            if (!w_exec_ok) begin
                r_err      <= 1'b1;
                r_err_code <= w_exec_err;
            end
        end
    end

    assign alu_left  = w_second;
    assign alu_right = w_top;
    assign top       = w_top;
    assign depth     = w_depth;
    assign err       = r_err;
    assign err_code  = r_err_code;
endmodule

// File: tb/tb_rpn_exec.sv
// Self-checking bench for rpn_exec with a reference ALU and a result scoreboard.
module tb_rpn_exec;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tok_valid = 1'b0;
    logic             tok_ready;
    logic             tok_is_op = 1'b0;
    logic [3:0]       tok_op = 4'd0;
    logic [WIDTH-1:0] tok_num = '0;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_left, alu_right, alu_ans;
    logic [1:0]       alu_arg_cnt;
    logic [WIDTH-1:0] top;
    logic [DW-1:0]    depth;
    logic             res_valid, err;
    logic [2:0]       err_code;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] sb_q[$];

    rpn_exec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_op(tok_op), .tok_num(tok_num),
        .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_ans(alu_ans), .alu_arg_cnt(alu_arg_cnt), .top(top), .depth(depth),
        .res_valid(res_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference ALU; divide by zero yields all ones.
    always_comb begin
        alu_ans     = '0;
        alu_arg_cnt = 2'd0;
        case (alu_op)
            4'd0: begin alu_ans = alu_left + alu_right; alu_arg_cnt = 2'd2; end
            4'd1: begin alu_ans = alu_left - alu_right; alu_arg_cnt = 2'd2; end
            4'd2: begin alu_ans = alu_left * alu_right; alu_arg_cnt = 2'd2; end
            4'd3: begin
                alu_ans     = (alu_right == '0) ? '1 : alu_left / alu_right;
                alu_arg_cnt = 2'd2;
            end
            4'd4: alu_arg_cnt = 2'd1;
            default: alu_arg_cnt = 2'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy();
        int n = 0;
        @(negedge clk);
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy_timeout", n, 0);
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        wait_rdy();
        tok_valid = 1'b1; tok_is_op = 1'b0; tok_num = v;
        @(posedge clk); #1;
        tok_valid = 1'b0;
    endtask

    // Drives an operator; a number offered during EXEC must be ignored.
    task automatic op(input logic [3:0] code, input bit ok, input logic [WIDTH-1:0] exp_top);
        logic [WIDTH-1:0] e;
        wait_rdy();
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = code;
        if (ok) sb_q.push_back(exp_top);
        @(posedge clk); #1;
        tok_is_op = 1'b0; tok_num = 16'd99;
        @(negedge clk);
        tok_valid = 1'b0;
        check("exec_op", alu_op, code);
        check("exec_rdy", tok_ready, 0);
        check("exec_vld", res_valid, 0);
        @(negedge clk);
        check("wb_vld", res_valid, ok);
        if (res_valid) begin
            check("sb_size", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                @(negedge clk);
                check("wb_top", top, e);
                check("wb_rdy", tok_ready, 1);
            end
        end else begin
            check("err_rdy", tok_ready, 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_rdy", tok_ready, 0);
        check("rst_depth", depth, 0);
        check("rst_top", top, 0);
        check("rst_err", {err, err_code}, 0);
        check("rst_vld", res_valid, 0);
        check("rst_aluop", alu_op, 4'hF);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // 10 + 20
        push(16'd10); push(16'd20);
        op(4'd0, 1'b1, 16'd30);
        check("add_depth", depth, 1);
        check("add_err", err, 0);

        // 20 - 10, then * 3
        do_reset();
        push(16'd20); push(16'd10);
        op(4'd1, 1'b1, 16'd10);
        push(16'd3);
        op(4'd2, 1'b1, 16'd30);
        check("mul_depth", depth, 1);

        // Wraparound modulo 2^WIDTH
        push(16'hFFFF); push(16'd2);
        op(4'd0, 1'b1, 16'd1);
        check("wrap_depth", depth, 2);

        // Overflow on full stack, then a good token clears the error
        do_reset();
        for (int i = 1; i <= DEPTH; i++) push(WIDTH'(i));
        push(16'd1);
        @(negedge clk);
        check("ovf_err", err, 1);
        check("ovf_code", err_code, 1);
        check("ovf_depth", depth, DEPTH);
        check("ovf_top", top, DEPTH);
        op(4'd4, 1'b1, WIDTH'(DEPTH - 1));
        check("pop_depth", depth, DEPTH - 1);
        check("pop_clr", {err, err_code}, 0);

        // Underflow on empty stack, unknown operator with two entries
        do_reset();
        op(4'd0, 1'b0, '0);
        check("unf_code", {err, err_code}, {1'b1, 3'd2});
        check("unf_depth", depth, 0);
        push(16'd1); push(16'd2);
        check("push_clr", err, 0);
        op(4'hF, 1'b0, '0);
        check("unk_code", {err, err_code}, {1'b1, 3'd3});
        check("unk_depth", depth, 2);
        check("unk_top", top, 2);

        // Divide by zero
        do_reset();
        push(16'd5); push(16'd0);
`ifdef RPN_DIV0_CHECK_EN
        op(4'd3, 1'b0, '0);
        check("div0_code", {err, err_code}, {1'b1, 3'd4});
        check("div0_depth", depth, 2);
`else
        op(4'd3, 1'b1, 16'hFFFF);
        check("div0_err", err, 0);
        check("div0_depth", depth, 1);
`endif

        // Reset during EXEC aborts the operator
        do_reset();
        push(16'd7); push(16'd8);
        wait_rdy();
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 4'd0;
        @(posedge clk); #1;
        tok_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_exec_rdy", tok_ready, 0);
        @(negedge clk);
        check("abort_vld", res_valid, 0);
        check("abort_depth", depth, 0);
        check("abort_top", top, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_vld2", res_valid, 0);
        check("abort_rdy", tok_ready, 1);

        check("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
